// File: rtl/nonrestoring_divider_p_pkg.sv
// div_pkg: shared types and helpers for the non-restoring divider.
//   state_t  : controller states IDLE/PREP/ITER/FIX
//   cnt_w    : counter width able to hold 0..width+1
//   abs_val  : magnitude of a sign-extended 64-bit operand
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

    // x must be sign-extended to 64 bits by the caller. The caller keeps only
    // the low WIDTH bits, so -2^(W-1) yields magnitude 2^(W-1).
    function automatic logic [63:0] abs_val(input logic [63:0] x, input logic signed_mode);
        return (signed_mode && x[63]) ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/nonrestoring_divider_p_lod.sv
// leading_one_detect: bit length of an unsigned value (MSB index + 1, 0 for zero).
//   x   : value to measure
//   len : bit length, 0..WIDTH
module leading_one_detect
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] x,
    output logic [LEN_W-1:0] len
);

    always_comb begin
        len = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                len = LEN_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/nonrestoring_divider_p.sv
// nonrestoring_divider_p: multi-cycle non-restoring integer divider.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request, accepted only while busy is low
//   signed_mode         : 1 = two's-complement operands
//   dividend, divisor   : operands, captured with start
//   busy                : operation in flight
//   done                : one-cycle pulse, results valid from this cycle
//   div_by_zero         : divisor was zero (valid with done)
//   q, rem              : quotient and remainder (truncating division)
//   num_add, num_sub    : additions (incl. correction) and subtractions used
module nonrestoring_divider_p
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rem,
    output logic [CNT_W-1:0] num_add,
    output logic [CNT_W-1:0] num_sub
);

    state_t state;

    logic [WIDTH-1:0]        a_cap;
    logic [WIDTH-1:0]        b_cap;
    logic                    sm_cap;
    logic signed [WIDTH:0]   r_acc;
    logic [WIDTH-1:0]        d_reg;
    logic [WIDTH-1:0]        q_acc;
    logic [CNT_W-1:0]        it_left;
    logic                    sc_flag;
    logic                    dz_flag;

    logic [63:0]             a_ext;
    logic [63:0]             b_ext;
    logic [WIDTH-1:0]        a_mag;
    logic [WIDTH-1:0]        b_mag;
    logic [CNT_W-1:0]        m_len;
    logic [CNT_W-1:0]        n_len;
    logic [CNT_W-1:0]        k_val;
    logic [WIDTH-1:0]        d_init;
    logic signed [WIDTH:0]   r_add;
    logic signed [WIDTH:0]   r_sub;
    logic signed [WIDTH:0]   r_next;
    logic [WIDTH-1:0]        r_corr;
    logic                    a_neg;
    logic                    b_neg;
    logic [WIDTH-1:0]        q_mag;
    logic [WIDTH-1:0]        r_mag;
    logic [WIDTH-1:0]        q_res;
    logic [WIDTH-1:0]        rem_res;

    leading_one_detect #(.WIDTH(WIDTH), .LEN_W(CNT_W)) u_lod_a (.x(a_mag), .len(m_len));
    leading_one_detect #(.WIDTH(WIDTH), .LEN_W(CNT_W)) u_lod_b (.x(b_mag), .len(n_len));

    always_comb begin
        a_ext  = 64'($signed(a_cap));
        b_ext  = 64'($signed(b_cap));
        a_mag  = WIDTH'(abs_val(a_ext, sm_cap));
        b_mag  = WIDTH'(abs_val(b_ext, sm_cap));
        k_val  = m_len - n_len;
        d_init = b_mag << k_val;

        r_add  = r_acc + $signed({1'b0, d_reg});
        r_sub  = r_acc - $signed({1'b0, d_reg});
        r_next = r_acc[WIDTH] ? r_add : r_sub;
        // In FIX d_reg has been walked back down to |b|, so r_add is the correction.
        r_corr = WIDTH'(r_acc[WIDTH] ? r_add : r_acc);

        a_neg  = sm_cap & a_cap[WIDTH-1];
        b_neg  = sm_cap & b_cap[WIDTH-1];
        q_mag  = sc_flag ? '0 : q_acc;
        r_mag  = sc_flag ? a_mag : r_corr;

        if (dz_flag) begin
            q_res   = '1;
            rem_res = a_cap;
        end else begin
            q_res   = (a_neg ^ b_neg) ? ('0 - q_mag) : q_mag;
            rem_res = a_neg ? ('0 - r_mag) : r_mag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            q           <= '0;
            rem         <= '0;
            num_add     <= '0;
            num_sub     <= '0;
            a_cap       <= '0;
            b_cap       <= '0;
            sm_cap      <= 1'b0;
            r_acc       <= '0;
            d_reg       <= '0;
            q_acc       <= '0;
            it_left     <= '0;
            sc_flag     <= 1'b0;
            dz_flag     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_cap       <= dividend;
                        b_cap       <= divisor;
                        sm_cap      <= signed_mode;
                        num_add     <= '0;
                        num_sub     <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= PREP;
                    end
                end
                PREP: begin
                    sc_flag <= 1'b0;
                    dz_flag <= 1'b0;
                    if (b_mag == '0) begin
                        dz_flag <= 1'b1;
                        state   <= FIX;
                    end else if (m_len < n_len) begin
                        sc_flag <= 1'b1;
                        state   <= FIX;
                    end else begin
                        r_acc   <= $signed({1'b0, a_mag});
                        d_reg   <= d_init;
                        q_acc   <= '0;
                        it_left <= k_val;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    r_acc <= r_next;
                    if (r_acc[WIDTH]) begin
                        num_add <= num_add + CNT_W'(1);
                    end else begin
                        num_sub <= num_sub + CNT_W'(1);
                    end
                    q_acc <= {q_acc[WIDTH-2:0], ~r_next[WIDTH]};
                    if (it_left == '0) begin
                        state <= FIX;
                    end else begin
                        d_reg   <= d_reg >> 1;
                        it_left <= it_left - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!dz_flag && !sc_flag && r_acc[WIDTH]) begin
                        num_add <= num_add + CNT_W'(1);
                    end
                    q           <= q_res;
                    rem         <= rem_res;
                    div_by_zero <= dz_flag;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider_p.sv
module tb_nonrestoring_divider_p;

    localparam int CW32 = $clog2(32 + 2);
    localparam int CW8  = $clog2(8 + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            start32 = 1'b0, sm32 = 1'b0;
    logic [31:0]     a32 = '0, b32 = '0;
    logic            busy32, done32, dz32;
    logic [31:0]     q32, r32;
    logic [CW32-1:0] na32, ns32;

    logic            start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]      a8 = '0, b8 = '0;
    logic            busy8, done8, dz8;
    logic [7:0]      q8, r8;
    logic [CW8-1:0]  na8, ns8;

    int n_tests = 0;
    int n_fail  = 0;

    nonrestoring_divider_p #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .div_by_zero(dz32), .q(q32), .rem(r32), .num_add(na32), .num_sub(ns32)
    );

    nonrestoring_divider_p #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .div_by_zero(dz8), .q(q8), .rem(r8), .num_add(na8), .num_sub(ns8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sm;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
    } vec_t;

    function automatic int unsigned bitlen(input logic [63:0] x);
        int unsigned len = 0;
        while (x != 0) begin
            x = x >> 1;
            len++;
        end
        return len;
    endfunction

    // Reference: plain integer division for results. Operation counts come from
    // the quotient bits: the first step always subtracts, each later step
    // subtracts iff the previous quotient bit is 1, and a final 0 bit needs a
    // correction add.
    function automatic void ref_div(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                    input bit sm, output logic [63:0] qe, output logic [63:0] re,
                                    output bit dze, output int unsigned nae, output int unsigned nse,
                                    output int unsigned late);
        logic [63:0] mask, am, bm, qm;
        bit an, bn;
        longint sa, sb, sq, sr;
        int unsigned m, n, k;
        mask = (64'd1 << w) - 64'd1;
        an = sm && a[w-1];
        bn = sm && b[w-1];
        am = an ? ((~a + 64'd1) & mask) : a;
        bm = bn ? ((~b + 64'd1) & mask) : b;
        nae = 0;
        nse = 0;
        if (bm == 0) begin
            qe = mask; re = a; dze = 1'b1; late = 2;
            return;
        end
        dze = 1'b0;
        sa = an ? -longint'(am) : longint'(am);
        sb = bn ? -longint'(bm) : longint'(bm);
        sq = sa / sb;
        sr = sa % sb;
        qe = 64'(sq) & mask;
        re = 64'(sr) & mask;
        m = bitlen(am);
        n = bitlen(bm);
        if (m < n) begin
            late = 2;
            return;
        end
        k = m - n;
        qm = am / bm;
        nse = 1;
        for (int unsigned j = k; j >= 1; j--) begin
            if (qm[j]) nse++;
        end
        nae = (k + 1 - nse) + (qm[0] ? 0 : 1);
        late = k + 3;
    endfunction

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit sm,
                         output logic [31:0] qo, output logic [31:0] ro, output bit dzo,
                         output int unsigned nao, output int unsigned nso,
                         output int unsigned lato, output bit to);
        a32 = a; b32 = b; sm32 = sm; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lato = 0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lato++;
            if (done32) begin
                to = 1'b0;
                break;
            end
        end
        qo = q32; ro = r32; dzo = dz32;
        nao = int'(na32); nso = int'(ns32);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy32, done32, dz32} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags32 got %b expected 000", {busy32, done32, dz32});
        end
        n_tests++;
        if ({q32, r32} !== 64'd0) begin
            n_fail++; $display("FAIL reset_qr32 got %h/%h expected 0/0", q32, r32);
        end
        n_tests++;
        if ({na32, ns32} !== '0) begin
            n_fail++; $display("FAIL reset_cnt32 got %0d/%0d expected 0/0", na32, ns32);
        end
        n_tests++;
        if ({busy8, done8, dz8, q8, r8, na8, ns8} !== '0) begin
            n_fail++; $display("FAIL reset_all8 got b%b d%b z%b q%h r%h a%0d s%0d expected all 0",
                               busy8, done8, dz8, q8, r8, na8, ns8);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t v [13];
        logic [31:0] qo, ro;
        bit dzo, to, dze;
        int unsigned nao, nso, lato, nae, nse, late;
        logic [63:0] qe, re;
        v = '{
            '{32'd8,          32'd3,          1'b0, 32'd2,          32'd2,          1'b0},
            '{32'd7,          32'd2,          1'b0, 32'd3,          32'd1,          1'b0},
            '{32'd3,          32'd5,          1'b0, 32'd0,          32'd3,          1'b0},
            '{32'd0,          32'd9,          1'b0, 32'd0,          32'd0,          1'b0},
            '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0},
            '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0},
            '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0},
            '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0},
            '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0},
            '{32'h80000000,   32'hFFFFFFF9,   1'b1, 32'h12492492,   32'hFFFFFFFE,   1'b0},
            '{32'h00001234,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h00001234,   1'b1},
            '{32'hFFFFFFF9,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1},
            '{32'd100,        32'd7,          1'b1, 32'd14,         32'd2,          1'b0}
        };
        for (int i = 0; i < 13; i++) begin
            ref_div(32, 64'(v[i].a), 64'(v[i].b), v[i].sm, qe, re, dze, nae, nse, late);
            run32(v[i].a, v[i].b, v[i].sm, qo, ro, dzo, nao, nso, lato, to);
            n_tests++;
            if (to) begin
                n_fail++; $display("FAIL dir[%0d] timeout: no done within 100 cycles", i);
                continue;
            end
            n_tests++;
            if (qo !== v[i].q) begin
                n_fail++; $display("FAIL dir[%0d] q got %h expected %h", i, qo, v[i].q);
            end
            n_tests++;
            if (ro !== v[i].r) begin
                n_fail++; $display("FAIL dir[%0d] rem got %h expected %h", i, ro, v[i].r);
            end
            n_tests++;
            if (dzo !== v[i].dz) begin
                n_fail++; $display("FAIL dir[%0d] div_by_zero got %b expected %b", i, dzo, v[i].dz);
            end
            n_tests++;
            if (nao != nae || nso != nse) begin
                n_fail++; $display("FAIL dir[%0d] counts add/sub got %0d/%0d expected %0d/%0d",
                                   i, nao, nso, nae, nse);
            end
            n_tests++;
            if (lato != late) begin
                n_fail++; $display("FAIL dir[%0d] latency got %0d expected %0d", i, lato, late);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] qo, ro;
        bit dzo, to, seen;
        int unsigned nao, nso, lato;
        a32 = 32'hFFFFFFFF; b32 = 32'd1; sm32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy32, done32, dz32, q32, r32, na32, ns32} !== '0) begin
            n_fail++; $display("FAIL reset_mid outputs got b%b d%b z%b q%h r%h a%0d s%0d expected all 0",
                               busy32, done32, dz32, q32, r32, na32, ns32);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 || busy32) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL reset_mid_quiet got done/busy activity 1 expected 0");
        end
        run32(32'd100, 32'd10, 1'b0, qo, ro, dzo, nao, nso, lato, to);
        n_tests++;
        if (to || qo !== 32'd10 || ro !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_after got to%b q%h r%h expected to0 q0000000a r00000000",
                               to, qo, ro);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] qe, re;
        bit dze, got;
        int unsigned nae, nse, late, lat;
        // A = 1000/3 unsigned, B = -100/7 signed, start held high across done.
        a32 = 32'd1000; b32 = 32'd3; sm32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy32 !== 1'b1) begin
            n_fail++; $display("FAIL b2b busy_after_accept got %b expected 1", busy32);
        end
        ref_div(32, 64'd1000, 64'd3, 1'b0, qe, re, dze, nae, nse, late);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom); start32 = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (done32) begin got = 1'b1; break; end
        end
        n_tests++;
        if (!got || q32 !== qe[31:0] || r32 !== re[31:0] || lat != late) begin
            n_fail++; $display("FAIL b2b first got done%b q%h r%h lat%0d expected done1 q%h r%h lat%0d",
                               got, q32, r32, lat, qe[31:0], re[31:0], late);
        end
        a32 = 32'hFFFFFF9C; b32 = 32'd7; sm32 = 1'b1; start32 = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy32 !== 1'b1 || done32 !== 1'b0) begin
            n_fail++; $display("FAIL b2b second_accept got busy%b done%b expected busy1 done0", busy32, done32);
        end
        start32 = 1'b0;
        ref_div(32, 64'hFFFFFF9C, 64'd7, 1'b1, qe, re, dze, nae, nse, late);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done32) begin got = 1'b1; break; end
        end
        n_tests++;
        if (!got || q32 !== 32'hFFFFFFF2 || r32 !== 32'hFFFFFFFE || lat != late) begin
            n_fail++; $display("FAIL b2b second got done%b q%h r%h lat%0d expected done1 qfffffff2 rfffffffe lat%0d",
                               got, q32, r32, lat, late);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done32 !== 1'b0 || busy32 !== 1'b0) begin
            n_fail++; $display("FAIL b2b done_pulse got done%b busy%b expected 0 0", done32, busy32);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (q32 !== 32'hFFFFFFF2 || r32 !== 32'hFFFFFFFE) begin
            n_fail++; $display("FAIL b2b hold got q%h r%h expected qfffffff2 rfffffffe", q32, r32);
        end
    endtask

    task automatic test_random8();
        logic [7:0] a, b;
        bit sm, got, dze;
        logic [63:0] qe, re;
        int unsigned nae, nse, late, lat;
        a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
        a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 300; t++) begin
            ref_div(8, 64'(a), 64'(b), sm, qe, re, dze, nae, nse, late);
            lat = 0; got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                lat++;
                if (done8) begin got = 1'b1; break; end
            end
            n_tests++;
            if (!got) begin
                n_fail++; $display("FAIL rnd8[%0d] timeout: no done within 40 cycles", t);
                start8 = 1'b0;
                return;
            end
            n_tests++;
            if (q8 !== qe[7:0] || r8 !== re[7:0]) begin
                n_fail++; $display("FAIL rnd8[%0d] %h/%h sm%b got q%h r%h expected q%h r%h",
                                   t, a, b, sm, q8, r8, qe[7:0], re[7:0]);
            end
            n_tests++;
            if (dz8 !== dze || busy8 !== 1'b0) begin
                n_fail++; $display("FAIL rnd8[%0d] flags got dz%b busy%b expected dz%b busy0", t, dz8, busy8, dze);
            end
            n_tests++;
            if (int'(na8) != nae || int'(ns8) != nse) begin
                n_fail++; $display("FAIL rnd8[%0d] %h/%h sm%b counts add/sub got %0d/%0d expected %0d/%0d",
                                   t, a, b, sm, na8, ns8, nae, nse);
            end
            n_tests++;
            if (lat != late) begin
                n_fail++; $display("FAIL rnd8[%0d] latency got %0d expected %0d", t, lat, late);
            end
            if (t == 299) begin
                start8 = 1'b0;
                @(posedge clk); #1;
                break;
            end
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            sm = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                start8 = 1'b0;
                @(posedge clk); #1;
                n_tests++;
                if (done8 !== 1'b0) begin
                    n_fail++; $display("FAIL rnd8[%0d] done_width got %b expected 0", t, done8);
                end
            end
            a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nonrestoring_divider_p.md
# nonrestoring_divider_p

Parametrised, multi-cycle non-restoring integer divider that generalises the fixed 32-bit arithmetic block to any `WIDTH`. It adds a signed mode, internal operand-length detection (no caller-supplied m/n), divide-by-zero handling and a start/busy/done handshake with asynchronous reset. It sits beside the other arithmetic units and is driven by a controller that issues one division at a time.

## Interface
- `WIDTH`, 32: operand and result width; legal range 4..64.
- `CNT_W`, `$clog2(WIDTH+2)`: width of the add/sub counters; holds values up to WIDTH+1.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; sampled only when `busy`=0.
- `signed_mode` in 1: 1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `dividend` in WIDTH: sampled with `start`.
- `divisor` in WIDTH: sampled with `start`.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse; results valid from this cycle.
- `div_by_zero` out 1: set with `done` when divisor == 0.
- `q` out WIDTH: quotient.
- `rem` out WIDTH: remainder.
- `num_add` out CNT_W: additions performed, including the correction add.
- `num_sub` out CNT_W: subtractions performed.

## Operation
- Reset values: `busy`, `done`, `div_by_zero` = 0; `q`, `rem`, `num_add`, `num_sub` = 0; state IDLE.
- IDLE
  - If `start` is high: capture the operands and mode, clear the counters, set `busy`, go to PREP.
- PREP
  - Form magnitudes |a| and |b|. In unsigned mode these are the raw operands. In signed mode, negative operands are negated into WIDTH-bit unsigned form, so -2^(W-1) gives magnitude 2^(W-1).
  - m = bit length of |a|; n = bit length of |b|. Bit length is MSB index + 1, and 0 for zero.
  - If b == 0: go to FIX with the divide-by-zero flag set.
  - Else if m < n (this includes a == 0): go to FIX with the short-circuit flag set.
  - Else: k = m - n; R = |a| in a WIDTH+1-bit signed register; D = |b| << k; go to ITER.
- ITER: one operation per cycle, for exactly k+1 cycles.
  - If R >= 0: R = R - D and increment `num_sub`.
  - Else: R = R + D and increment `num_add`.
  - Shift the quotient left, inserting ~sign(new R). Shift D right by 1, except on the last iteration.
  - After the last iteration, go to FIX.
- FIX: produce the results.
  - If R < 0: R = R + D (D is now |b|) and increment `num_add`.
  - Short-circuit case: Q = 0, R = |a|, counters stay 0.
  - Signed mode: negate Q if the operand signs differ; negate R if the dividend is negative (truncating division).
  - Divide-by-zero case: `q` = all ones, `rem` = the raw captured dividend, `div_by_zero` = 1.
  - Register the outputs, pulse `done`, clear `busy`, go to IDLE.
- `start` while `busy` is ignored; no queueing.
- Outputs hold their values until the next accepted `start`. `div_by_zero` clears on the next acceptance.
- Signed overflow: -2^(W-1) / -1 gives `q` = -2^(W-1) (wraps) and `rem` = 0, with no flag.
- Reset mid-operation immediately returns to IDLE with all outputs at their reset values; no `done` is issued.

## Timing
- Call the edge that samples `start` edge 0.
- Normal case: `done` is high after edge k+3, so latency is k+3 cycles (maximum WIDTH+2). `busy` is high after edges 0 through k+2.
- Short-circuit and divide-by-zero: `done` is high after edge 2, so latency is 2 cycles.
- `start` may be high in the same cycle as `done`. It is accepted, because `busy`=0 in that cycle, giving back-to-back throughput.
- `done` is exactly one cycle wide and never asserts without a preceding acceptance.

## Structure
- Package `div_pkg` contains:
  - the state enum IDLE/PREP/ITER/FIX;
  - a function `cnt_w(width)` returning `$clog2(width+2)`;
  - a function `abs_val(x, signed_mode)`.
- Sub-module `leading_one_detect`, parameterised by WIDTH, returns the bit length. It is instantiated twice, once for each magnitude.
- All remaining datapath logic stays in the top module.

## Test plan
- Unsigned, WIDTH=32, 8 / 3 → `q`=2, `rem`=2, `num_sub`=2, `num_add`=2 (one of them the correction add), `done` after 5 cycles (k=2).
- Unsigned 7 / 2 → `q`=3, `rem`=1, `num_sub`=2, `num_add`=0; also 3 / 5 → `q`=0, `rem`=3, latency 2, counters 0.
- Signed -7 / 2 → `q`=-3, `rem`=-1; 7 / -2 → `q`=-3, `rem`=1; 0x80000000 / -1 → `q`=0x80000000, `rem`=0.
- Divisor 0 with dividend 0x1234 → `div_by_zero`=1, `q`=0xFFFFFFFF, `rem`=0x1234, latency 2.
- Assert `rst` on the fourth ITER cycle of 0xFFFFFFFF / 1 → all outputs 0 and no `done` pulse; the next `start` with 100 / 10 yields `q`=10, `rem`=0.
- Back-to-back: `start` held high through `done` → second division accepted on the `done` cycle; `start` pulses while `busy` → ignored. Repeat at WIDTH=8 with random operands checked against a reference model.
